// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter that lends the write side of one byte FIFO to NUM_REQ packet sources.
// Optional header byte per packet when TX_ARB_HEADER_EN is defined.
module tx_fifo_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8,
  parameter int LEN_BIT = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_BIT-1:0] req_len,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         data_ack,
  output logic                       busy,
  output logic                       fifo_write_flag,
  output logic [WIDTH-1:0]           fifo_write_data,
  input  logic                       fifo_full
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef TX_ARB_HEADER_EN
    S_HEADER = 2'd1,
`endif
    S_SEND   = 2'd2
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [LEN_BIT-1:0]   count_q;
  logic                 busy_q;

  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  int                   scan;
  logic                 payload_phase;
  logic                 hdr_phase;
  logic                 wr_en;
  logic [WIDTH-1:0]     hdr_byte;

  // Scan from the highest offset down so the entry nearest rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (req[scan]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(scan);
      end
    end
  end

  assign rr_ptr_d = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;

  // Write strobe is also gated by reset so an abandoned packet leaks no byte at the FIFO's negedge.
  always_comb begin
    payload_phase = (state_q == S_SEND);
`ifdef TX_ARB_HEADER_EN
    hdr_phase     = (state_q == S_HEADER);
    hdr_byte      = '0;
    hdr_byte[LEN_BIT-1:0]   = count_q;
    hdr_byte[LEN_BIT +: 2]  = 2'(idx_q);
`else
    hdr_phase     = 1'b0;
    hdr_byte      = '0;
`endif
    wr_en = RST_N && !fifo_full && (payload_phase || hdr_phase);
  end

  assign fifo_write_flag = wr_en;
  assign fifo_write_data = hdr_phase ? hdr_byte : req_data[int'(idx_q)*WIDTH +: WIDTH];
  assign data_ack        = (wr_en && payload_phase) ? grant_q : '0;
  assign grant           = grant_q;
  assign busy            = busy_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q <= NUM_REQ'(1) << pick_idx;
            idx_q   <= pick_idx;
            count_q <= req_len[int'(pick_idx)*LEN_BIT +: LEN_BIT];
            busy_q  <= 1'b1;
`ifdef TX_ARB_HEADER_EN
            state_q <= S_HEADER;
`else
            state_q <= S_SEND;
`endif
          end
        end
`ifdef TX_ARB_HEADER_EN
        S_HEADER: begin
          if (wr_en) state_q <= S_SEND;
        end
`endif
        S_SEND: begin
          if (wr_en) begin
            if (count_q == '0) begin
              state_q  <= S_IDLE;
              grant_q  <= '0;
              busy_q   <= 1'b0;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Scoreboard bench for tx_fifo_arbiter: stimulus queues expected FIFO writes, a negedge monitor checks them.
module tb_tx_fifo_arbiter;

`ifdef TX_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ack;
  } exp_t;

  logic       CLK;
  logic       RST_N;
  logic [1:0] req;
  logic [7:0] req_len;
  logic [15:0] req_data;
  logic [1:0] grant;
  logic [1:0] data_ack;
  logic       busy;
  logic       fifo_write_flag;
  logic [7:0] fifo_write_data;
  logic       fifo_full;

  logic [3:0] len_v  [2];
  logic [7:0] base   [2];
  logic [7:0] ptr    [2];
  logic [7:0] stop_at[2];

  exp_t exp_q[$];
  int   wr_cyc[$];
  exp_t e;
  int   cyc = 0;
  int   n_wr = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  assign req_len  = {len_v[1], len_v[0]};
  assign req_data = {8'(base[1] + ptr[1]), 8'(base[0] + ptr[0])};

  tx_fifo_arbiter #(.NUM_REQ(2), .WIDTH(8), .LEN_BIT(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .req_len(req_len), .req_data(req_data),
    .grant(grant), .data_ack(data_ack), .busy(busy),
    .fifo_write_flag(fifo_write_flag), .fifo_write_data(fifo_write_data), .fifo_full(fifo_full)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, want);
  endtask

  // Monitor: samples on negedge, where the FIFO itself samples.
  always @(negedge CLK) begin
    if (fifo_write_flag) begin
      n_wr <= n_wr + 1;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL extra_write: got data %0h ack %0h expected no write", fifo_write_data, data_ack);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", fifo_write_data, e.data);
        chk("wr_ack", data_ack, e.ack);
      end
    end else if (data_ack != 2'b00) begin
      chk("ack_without_write", data_ack, 0);
    end
    if (fifo_full) chk("stall_quiet", {fifo_write_flag, data_ack}, 0);
  end

  // One cycle of the source model: acks seen this cycle advance the source's byte pointer.
  task automatic step();
    logic [1:0] a;
    @(negedge CLK);
    a = data_ack;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (a[i]) begin
        ptr[i] = ptr[i] + 8'd1;
        if (ptr[i] == stop_at[i]) req[i] = 1'b0;
      end
    end
  endtask

  task automatic expect_pkt(input int src, input int len, input logic [7:0] b);
    exp_t x;
`ifdef TX_ARB_HEADER_EN
    x.data = 8'((src << 4) | len);
    x.ack  = 2'b00;
    exp_q.push_back(x);
`endif
    for (int k = 0; k <= len; k++) begin
      x.data = b + 8'(k);
      x.ack  = 2'(1 << src);
      exp_q.push_back(x);
    end
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 300 && (exp_q.size() != 0 || busy); n++) step();
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_grant"}, grant, 0);
  endtask

  task automatic setup_src(input int i, input logic [3:0] l, input logic [7:0] b, input logic [7:0] s);
    len_v[i] = l;
    base[i] = b;
    ptr[i] = 8'd0;
    stop_at[i] = s;
  endtask

  initial begin
    int n0;
    int want;
    RST_N = 1'b0;
    fifo_full = 1'b0;
    req = 2'b11;
    setup_src(0, 4'd1, 8'h10, 8'd4);
    setup_src(1, 4'd1, 8'h20, 8'd2);

    // Reset with both requesting, then round-robin contention.
    expect_pkt(0, 1, 8'h10);
    expect_pkt(1, 1, 8'h20);
    expect_pkt(0, 1, 8'h12);
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wflag", fifo_write_flag, 0);
    wr_cyc.delete();
    RST_N = 1'b1;
    step();
    chk("first_grant", grant, 2'b01);
    chk("first_busy", busy, 1);
    drain("contention");
    chk("contention_writes", wr_cyc.size(), 6 + 3*HDR);
    if (wr_cyc.size() == 6 + 3*HDR) begin
      for (int k = 1; k < 6 + 3*HDR; k++) begin
        want = (k % (2 + HDR) == 0) ? 2 : 1;
        chk("write_spacing", wr_cyc[k] - wr_cyc[k-1], want);
      end
    end

    // Single 4-byte packet from source 1.
    setup_src(1, 4'd3, 8'hA0, 8'd4);
    expect_pkt(1, 3, 8'hA0);
    n0 = n_wr;
    req = 2'b10;
    step();
    chk("single_grant", grant, 2'b10);
    drain("single");
    chk("single_writes", n_wr - n0, 4 + HDR);

    // Back-pressure: FIFO full for 3 cycles after two payload bytes.
    setup_src(0, 4'd3, 8'h40, 8'd4);
    expect_pkt(0, 3, 8'h40);
    n0 = n_wr;
    req = 2'b01;
    for (int n = 0; n < 100 && ptr[0] != 8'd2; n++) step();
    chk("bp_reached", ptr[0], 2);
    fifo_full = 1'b1;
    step();
    step();
    step();
    chk("bp_no_progress", ptr[0], 2);
    chk("bp_still_busy", busy, 1);
    fifo_full = 1'b0;
    drain("backpressure");
    chk("bp_writes", n_wr - n0, 4 + HDR);

    // Header packet: source 1, length field 5.
    setup_src(1, 4'd5, 8'hB0, 8'd6);
    expect_pkt(1, 5, 8'hB0);
    n0 = n_wr;
    req = 2'b10;
    drain("header_pkt");
    chk("header_pkt_writes", n_wr - n0, 6 + HDR);

    // Reset after the 2nd of 8 bytes; rr_ptr must restart at 0.
    setup_src(1, 4'd7, 8'h60, 8'd8);
    expect_pkt(1, 1, 8'h60);
    exp_q.delete();
`ifdef TX_ARB_HEADER_EN
    e.data = 8'h17;
    e.ack  = 2'b00;
    exp_q.push_back(e);
`endif
    e.data = 8'h60; e.ack = 2'b10; exp_q.push_back(e);
    e.data = 8'h61; e.ack = 2'b10; exp_q.push_back(e);
    req = 2'b10;
    for (int n = 0; n < 100 && ptr[1] != 8'd2; n++) step();
    chk("midrst_reached", ptr[1], 2);
    RST_N = 1'b0;
    n0 = n_wr;
    step();
    step();
    req = 2'b00;
    chk("midrst_writes", n_wr - n0, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pending", exp_q.size(), 0);
    setup_src(0, 4'd0, 8'h80, 8'd1);
    setup_src(1, 4'd0, 8'h90, 8'd1);
    expect_pkt(0, 0, 8'h80);
    expect_pkt(1, 0, 8'h90);
    RST_N = 1'b1;
    req = 2'b11;
    step();
    chk("midrst_rr_grant", grant, 2'b01);
    drain("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_fifo_arbiter.md
Name: tx_fifo_arbiter

Overview:
Shares the write side of one byte FIFO between NUM_REQ packet sources, e.g. the debug/UART transmit path. A round-robin grant is held for a whole packet. The granted source's bytes stream into the FIFO under full back-pressure. A per-source ack tells the source when each byte has been taken.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
WIDTH, 8, data width; must match the FIFO's WIDTH.
LEN_BIT, 4, packet length field width; packet length = req_len + 1, so 1..2^LEN_BIT bytes.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST_N  input  1  synchronous, active-low reset.
req  input  NUM_REQ  source i has a packet pending; must stay high until its last ack.
req_len  input  NUM_REQ*LEN_BIT  flattened; slice i = length-1 of source i's packet; sampled at grant.
req_data  input  NUM_REQ*WIDTH  flattened; slice i = source i's current byte.
grant  output  NUM_REQ  registered one-hot owner of the FIFO; 0 when idle.
data_ack  output  NUM_REQ  combinational; pulse on source i when its current byte is written; source presents the next byte on the following cycle.
busy  output  1  high whenever state is not IDLE.
fifo_write_flag  output  1  to FIFO write_flag.
fifo_write_data  output  WIDTH  to FIFO write_data.
fifo_full  input  1  from FIFO full.

Behaviour:
- Reset (RST_N low at posedge):
  - state=IDLE, grant=0, busy=0, rr_ptr=0, count=0.
  - Outputs fifo_write_flag=0 and data_ack=0.
  - Takes effect mid-packet too: the partial packet is abandoned with no further writes.
- States: IDLE, HEADER (only with the macro), SEND.
- IDLE:
  - If any req bit is set, pick the first set index scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
  - At the next posedge: grant=onehot(index), count=req_len[index], state=SEND (or HEADER).
  - No FIFO write occurs in IDLE.
- SEND:
  - fifo_write_flag = !fifo_full (combinational).
  - fifo_write_data = req_data slice of the granted index.
  - data_ack[granted] = fifo_write_flag.
  - On each posedge with fifo_write_flag=1 and count!=0: count decrements.
  - On the posedge with fifo_write_flag=1 and count==0 (last byte):
    - state=IDLE, grant=0.
    - rr_ptr = granted index + 1, wrapping mod NUM_REQ.
  - While fifo_full=1: no write, no ack, state and count held (stall of any length).
- Throughput and latency:
  - 1 byte per cycle when not full.
  - Min 1 idle cycle between packets (IDLE bubble).
  - First byte written no earlier than 1 cycle after req rises (2 with header).
- req and req_len are ignored during a packet. Dropping req early does not shorten the packet.
- Only the granted source ever sees data_ack. data_ack and grant are never set for two sources at once.
- Simultaneous requests: strict round-robin. A source just served has lowest priority at the next arbitration.
- The FIFO is clocked on negedge. The arbiter holds write_flag/write_data stable across the whole high phase, so the FIFO samples them mid-cycle.

Optional Feature:
TX_ARB_HEADER_EN: when defined, each packet is preceded by one header byte written in state HEADER.
- Header contents:
  - bits [LEN_BIT-1:0] = latched length-1.
  - bits [LEN_BIT+1:LEN_BIT] = granted index.
  - remaining bits = 0.
  - Requires LEN_BIT+2 <= WIDTH.
- HEADER obeys fifo_full like SEND, asserts no data_ack, then moves to SEND.
- Without the macro: no HEADER state; IDLE goes directly to SEND and only payload bytes are written.

Test Plan:
1. Reset: RST_N low 2 cycles with req=2'b11 -> grant=0, busy=0, fifo_write_flag=0; after release, grant=2'b01 on the first posedge.
2. Single packet: req[1]=1, req_len slice=3, data 0xA0..0xA3 -> grant=2'b10, 4 consecutive writes A0,A1,A2,A3, 4 data_ack[1] pulses, then grant=0 and busy=0.
3. Contention: req=2'b11 held, each len=1 -> packets write 0, 0, 1, 1, 0, 0 by source (alternating), with exactly one idle cycle between packets.
4. Back-pressure: fifo_full=1 for 3 cycles in the middle of a 4-byte packet -> no write or ack during those cycles; the byte order is preserved and exactly 4 writes occur in total.
5. Reset mid-packet: RST_N low after the 2nd of 8 bytes -> no further writes; state IDLE; rr_ptr=0 on release.
6. With TX_ARB_HEADER_EN, WIDTH=8, LEN_BIT=4: source 1, len field 5 -> first write 0x15, followed by 6 payload bytes; the header write produces no ack.
